// File: rtl/axis_dma_read_if.sv
// Bundle of the DMA control, memory-read and AXI-Stream signals for axis_dma_read.
// master = the DMA engine, slave = the environment (memory + stream sink + controller).
interface axis_dma_read_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic              done;
  logic              busy;
  logic              mem_rd_valid;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_data_valid;
  logic [DATA_W-1:0] mem_rd_data;
  logic              M_AXIS_TVALID;
  logic [DATA_W-1:0] M_AXIS_TDATA;
  logic              M_AXIS_TREADY;
  logic              M_AXIS_TLAST;

  modport master (
    input  start, base_addr, length, mem_rd_data_valid, mem_rd_data, M_AXIS_TREADY,
    output done, busy, mem_rd_valid, mem_rd_addr, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST
  );

  modport slave (
    output start, base_addr, length, mem_rd_data_valid, mem_rd_data, M_AXIS_TREADY,
    input  done, busy, mem_rd_valid, mem_rd_addr, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST
  );
endinterface

// File: rtl/axis_dma_read.sv
// Memory-to-stream read DMA with a credit-limited output FIFO (requests + buffered <= FIFO_DEPTH).
// Optional: define AXIS_DMA_READ_TLAST_EN to drive M_AXIS_TLAST on the final beat.
module axis_dma_read #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  axis_dma_read_if.master    bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   issued_q, issued_d;
  logic [ADDR_W-1:0]   sent_q, sent_d;
  logic [CNT_W-1:0]    out_q, out_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic                req_vld_q, req_vld_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic fifo_nempty;
  logic pop;
  logic push;
  logic issue;
  logic credit_ok;

  assign fifo_nempty = (cnt_q != '0);
  assign pop         = fifo_nempty && bus.M_AXIS_TREADY;
  // Returns with nothing outstanding (stale after reset, or spurious) are dropped.
  assign push        = bus.mem_rd_data_valid && (state_q != S_IDLE) && (out_q != '0);
  assign credit_ok   = ({1'b0, out_q} + {1'b0, cnt_q}) < (CNT_W+1)'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    sent_d     = pop ? sent_q + ADDR_W'(1) : sent_q;
    req_vld_d  = 1'b0;
    req_addr_d = req_addr_q;
    issue      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          base_d = bus.base_addr;
          len_d  = bus.length;
          sent_d = '0;
          if (bus.length == '0) begin
            state_d  = S_DONE;
            issued_d = '0;
          end else begin
            // First request goes out straight from the start cycle.
            state_d    = S_RUN;
            issue      = 1'b1;
            req_vld_d  = 1'b1;
            req_addr_d = bus.base_addr;
            issued_d   = ADDR_W'(1);
          end
        end
      end
      S_RUN: begin
        if (issued_q == len_q) begin
          state_d = S_DRAIN;
        end else if ((issued_q < len_q) && credit_ok) begin
          issue      = 1'b1;
          req_vld_d  = 1'b1;
          req_addr_d = base_q + issued_q;
          issued_d   = issued_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (sent_d == len_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    out_d = out_q;
    if (issue && !push)      out_d = out_q + CNT_W'(1);
    else if (!issue && push) out_d = out_q - CNT_W'(1);

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);

    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      req_vld_q  <= 1'b0;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      req_vld_q  <= req_vld_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= bus.mem_rd_data;
  end

  assign bus.done          = (state_q == S_DONE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.mem_rd_valid  = req_vld_q;
  assign bus.mem_rd_addr   = req_addr_q;
  assign bus.M_AXIS_TVALID = fifo_nempty;
  assign bus.M_AXIS_TDATA  = fifo_mem[rptr_q];

`ifdef AXIS_DMA_READ_TLAST_EN
  assign bus.M_AXIS_TLAST  = fifo_nempty && (sent_q == (len_q - ADDR_W'(1)));
`else
  assign bus.M_AXIS_TLAST  = 1'b0;
`endif

endmodule

// File: tb/tb_axis_dma_read.sv
// Directed bench for axis_dma_read: latency-modelled byte memory, stream sink with backpressure.
module tb_axis_dma_read;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_dma_read_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  axis_dma_read #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int lat = 1;
  bit rnd_lat = 1'b0;
  int tready_mode = 0;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due = 0;

  logic [31:0] req_q[$];
  logic [7:0]  beat_q[$];
  bit          last_q[$];
  int first_req_cyc = -1, last_req_cyc = -1, last_beat_cyc = -1;
  int done_cnt = 0, done_cyc = -1, max_infl = 0, stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  // Stream sink ready: 0 always ready, 1 random, 2 held low.
  always @(posedge clk) begin
    #1;
    case (tready_mode)
      0:       bus.M_AXIS_TREADY = 1'b1;
      1:       bus.M_AXIS_TREADY = 1'($urandom_range(0, 1));
      default: bus.M_AXIS_TREADY = 1'b0;
    endcase
  end

  // Memory model, request/beat recorder and stability monitor.
  always @(negedge clk) begin : mon
    int d;
    int infl;
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      bus.mem_rd_data_valid = 1'b1;
      bus.mem_rd_data       = mq_addr[0][7:0] ^ 8'h5A;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      bus.mem_rd_data_valid = 1'b0;
    end
    if (bus.mem_rd_valid === 1'b1) begin
      d = cyc + (rnd_lat ? 1 + int'($urandom_range(0, 4)) : lat);
      if (d < last_due) d = last_due;
      last_due = d;
      mq_addr.push_back(bus.mem_rd_addr);
      mq_due.push_back(d);
      req_q.push_back(bus.mem_rd_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
      last_req_cyc = cyc;
    end
    infl = req_q.size() - beat_q.size();
    if (infl > max_infl) max_infl = infl;
    if (prev_stall && (bus.M_AXIS_TVALID !== 1'b1 || bus.M_AXIS_TDATA !== prev_data)) stab_err++;
    prev_stall = (bus.M_AXIS_TVALID === 1'b1) && (bus.M_AXIS_TREADY !== 1'b1);
    prev_data  = bus.M_AXIS_TDATA;
    if (bus.M_AXIS_TVALID === 1'b1 && bus.M_AXIS_TREADY === 1'b1) begin
      beat_q.push_back(bus.M_AXIS_TDATA);
      last_q.push_back(bus.M_AXIS_TLAST);
      last_beat_cyc = cyc;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    req_q.delete();
    beat_q.delete();
    last_q.delete();
    first_req_cyc = -1; last_req_cyc = -1; last_beat_cyc = -1;
    done_cnt = 0; done_cyc = -1; max_infl = 0; stab_err = 0;
  endtask

  task automatic start_xfer(input logic [31:0] b, input logic [31:0] l, output int sc);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = b; bus.length = l;
    sc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done_cnt > 0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.done, bus.busy, bus.mem_rd_valid, bus.M_AXIS_TVALID, bus.M_AXIS_TLAST} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {bus.done, bus.busy, bus.mem_rd_valid, bus.M_AXIS_TVALID, bus.M_AXIS_TLAST});
    end
    checks++;
    if (bus.mem_rd_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr: got %h want 00000000", bus.mem_rd_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int sc; bit ok; logic [7:0] e; bit el;
    lat = 1; rnd_lat = 1'b0; tready_mode = 0;
    clear_mon();
    start_xfer(32'h100, 32'd8, sc);
    wait_done(200, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done_timeout: got none want done"); end
    checks++;
    if (req_q.size() != 8) begin errors++; $display("FAIL basic_req_count: got %0d want 8", req_q.size()); end
    for (int i = 0; i < 8 && i < req_q.size(); i++) begin
      checks++;
      if (req_q[i] !== 32'h100 + i) begin errors++; $display("FAIL basic_addr[%0d]: got %h want %h", i, req_q[i], 32'h100 + i); end
    end
    checks++;
    if (beat_q.size() != 8) begin errors++; $display("FAIL basic_beat_count: got %0d want 8", beat_q.size()); end
    for (int i = 0; i < 8 && i < beat_q.size(); i++) begin
      e = 8'(i) ^ 8'h5A;
`ifdef AXIS_DMA_READ_TLAST_EN
      el = (i == 7);
`else
      el = 1'b0;
`endif
      checks++;
      if (beat_q[i] !== e) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, beat_q[i], e); end
      checks++;
      if (last_q[i] !== el) begin errors++; $display("FAIL basic_tlast[%0d]: got %b want %b", i, last_q[i], el); end
    end
    checks++;
    if (first_req_cyc != sc + 1) begin errors++; $display("FAIL basic_first_req: got cycle %0d want %0d", first_req_cyc, sc + 1); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    checks++;
    if (done_cyc != last_beat_cyc + 1) begin errors++; $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, last_beat_cyc + 1); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_credit();
    int sc; bit ok; logic [7:0] e;
    lat = 6; rnd_lat = 1'b0; tready_mode = 0;
    clear_mon();
    start_xfer(32'h200, 32'd16, sc);
    wait_done(400, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL credit_done_timeout: got none want done"); end
    checks++;
    if (beat_q.size() != 16) begin errors++; $display("FAIL credit_beat_count: got %0d want 16", beat_q.size()); end
    for (int i = 0; i < 16 && i < beat_q.size(); i++) begin
      e = 8'(i) ^ 8'h5A;
      checks++;
      if (beat_q[i] !== e) begin errors++; $display("FAIL credit_data[%0d]: got %h want %h", i, beat_q[i], e); end
    end
    checks++;
    if (max_infl != FIFO_DEPTH) begin errors++; $display("FAIL credit_max_inflight: got %0d want %0d", max_infl, FIFO_DEPTH); end
    checks++;
    if (last_req_cyc - first_req_cyc <= 15) begin errors++; $display("FAIL credit_req_gaps: got span %0d want >15", last_req_cyc - first_req_cyc); end
  endtask

  task automatic test_backpressure();
    int sc; bit ok; logic [7:0] e;
    rnd_lat = 1'b1; tready_mode = 2;
    clear_mon();
    start_xfer(32'h300, 32'd10, sc);
    repeat (20) @(negedge clk);
    checks++;
    if (req_q.size() != FIFO_DEPTH) begin errors++; $display("FAIL bp_req_stall: got %0d want %0d", req_q.size(), FIFO_DEPTH); end
    checks++;
    if (bus.M_AXIS_TVALID !== 1'b1) begin errors++; $display("FAIL bp_tvalid_held: got %b want 1", bus.M_AXIS_TVALID); end
    tready_mode = 1;
    wait_done(600, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_done_timeout: got none want done"); end
    checks++;
    if (beat_q.size() != 10) begin errors++; $display("FAIL bp_beat_count: got %0d want 10", beat_q.size()); end
    for (int i = 0; i < 10 && i < beat_q.size(); i++) begin
      e = 8'(i) ^ 8'h5A;
      checks++;
      if (beat_q[i] !== e) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, beat_q[i], e); end
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL bp_stability: got %0d violations want 0", stab_err); end
    checks++;
    if (max_infl > FIFO_DEPTH) begin errors++; $display("FAIL bp_max_inflight: got %0d want <=%0d", max_infl, FIFO_DEPTH); end
    rnd_lat = 1'b0; tready_mode = 0;
  endtask

  task automatic test_zero_len();
    int sc;
    lat = 1; tready_mode = 0;
    clear_mon();
    start_xfer(32'h400, 32'd0, sc);
    repeat (4) @(negedge clk);
    checks++;
    if (req_q.size() != 0) begin errors++; $display("FAIL zero_reqs: got %0d want 0", req_q.size()); end
    checks++;
    if (beat_q.size() != 0) begin errors++; $display("FAIL zero_beats: got %0d want 0", beat_q.size()); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end
    checks++;
    if (done_cyc != sc + 1) begin errors++; $display("FAIL zero_done_timing: got %0d want %0d", done_cyc, sc + 1); end
  endtask

  task automatic test_start_busy();
    int sc, sc2; bit ok; logic [7:0] e;
    lat = 1; tready_mode = 2;
    clear_mon();
    start_xfer(32'h500, 32'd5, sc);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_high: got %b want 1", bus.busy); end
    start_xfer(32'h600, 32'd2, sc2);
    tready_mode = 0;
    wait_done(200, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_done_timeout: got none want done"); end
    checks++;
    if (beat_q.size() != 5) begin errors++; $display("FAIL busy_beat_count: got %0d want 5", beat_q.size()); end
    checks++;
    if (req_q.size() != 5) begin errors++; $display("FAIL busy_req_count: got %0d want 5", req_q.size()); end
    for (int i = 0; i < 5 && i < beat_q.size() && i < req_q.size(); i++) begin
      e = 8'(8'h00 + i) ^ 8'h5A;
      checks++;
      if (req_q[i] !== 32'h500 + i) begin errors++; $display("FAIL busy_addr[%0d]: got %h want %h", i, req_q[i], 32'h500 + i); end
      checks++;
      if (beat_q[i] !== e) begin errors++; $display("FAIL busy_data[%0d]: got %h want %h", i, beat_q[i], e); end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL busy_done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    int sc; bit ok;
    logic [31:0] ea[4];
    logic [7:0]  ed[4];
    ea[0] = 32'hFFFF_FFFE; ea[1] = 32'hFFFF_FFFF; ea[2] = 32'h0000_0000; ea[3] = 32'h0000_0001;
    ed[0] = 8'hA4; ed[1] = 8'hA5; ed[2] = 8'h5A; ed[3] = 8'h5B;
    lat = 2; tready_mode = 0;
    clear_mon();
    start_xfer(32'hFFFF_FFFE, 32'd4, sc);
    wait_done(200, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_done_timeout: got none want done"); end
    checks++;
    if (req_q.size() != 4 || beat_q.size() != 4) begin
      errors++; $display("FAIL wrap_counts: got req=%0d beat=%0d want 4/4", req_q.size(), beat_q.size());
    end
    for (int i = 0; i < 4 && i < req_q.size() && i < beat_q.size(); i++) begin
      checks++;
      if (req_q[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, req_q[i], ea[i]); end
      checks++;
      if (beat_q[i] !== ed[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, beat_q[i], ed[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int sc; bit ok; bit hit;
    lat = 2; tready_mode = 0;
    clear_mon();
    start_xfer(32'h700, 32'd12, sc);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (beat_q.size() >= 3) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_three_beats: got %0d beats want 3", beat_q.size()); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.done, bus.busy, bus.mem_rd_valid, bus.M_AXIS_TVALID, bus.M_AXIS_TLAST} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b want 00000", {bus.done, bus.busy, bus.mem_rd_valid, bus.M_AXIS_TVALID, bus.M_AXIS_TLAST});
    end
    checks++;
    if (bus.mem_rd_addr !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h want 00000000", bus.mem_rd_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if ({bus.busy, bus.M_AXIS_TVALID} !== 2'b00) begin
      errors++; $display("FAIL rstmid_stale_dropped: got busy/tvalid=%b want 00", {bus.busy, bus.M_AXIS_TVALID});
    end
    clear_mon();
    start_xfer(32'h40, 32'd2, sc);
    wait_done(100, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_restart_timeout: got none want done"); end
    checks++;
    if (beat_q.size() != 2 || req_q.size() != 2) begin
      errors++; $display("FAIL rstmid_restart_counts: got req=%0d beat=%0d want 2/2", req_q.size(), beat_q.size());
    end else begin
      checks++;
      if ({beat_q[0], beat_q[1]} !== 16'h1A1B) begin
        errors++; $display("FAIL rstmid_restart_data: got %h%h want 1a1b", beat_q[0], beat_q[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_backpressure();
    test_zero_len();
    test_start_busy();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
